// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Holds the segment word type, the dark-segment pattern and the
// hex-to-segment glyph table used by the decoder.
package seven_seg_pkg;

  // {dp,g,f,e,d,c,b,a}, 1 = lit (before any output inversion)
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;

  // Glyphs for hex 0..F, bits {g,f,e,d,c,b,a}. Entry [15] is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-digit decoder: nibble + decimal point + blank -> seg_t.
// Ports: nibble (hex digit), dp (decimal point, 1 = lit),
//        blank (1 = force g..a dark), seg (decoded {dp,g..a}, active-high).
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    // The decimal point stays live on a blanked digit so fixed-point
    // readouts keep their dot even when the leading digits are suppressed.
    seg[7] = dp;
    if (!blank) begin
      seg[6:0] = hex_to_seg(nibble);
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Ports: clk, rst (sync, active-high), load (capture value/dp_in), value
//        (hex nibbles, [3:0] = digit 0), dp_in (per-digit dot), enable,
//        seg ({dp,g..a}), an (active-low digit enables), frame_done (pulse).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 100000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   POS_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);
  // Polarity is applied once, at the output register.
  localparam seg_t SEG_XOR  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam seg_t SEG_IDLE = SEG_OFF ^ SEG_XOR;

  logic [DIV_W-1:0]        div_cnt;
  logic [POS_W-1:0]        pos;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic                    tc;
  logic                    wrap;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_blank;
  seg_t                    cur_seg;

  assign tc         = (div_cnt == DIV_LAST);
  assign wrap       = tc && (pos == POS_LAST);
  assign frame_done = wrap;

  // Leading-zero mask: walk from the most significant digit down, blanking
  // while every nibble seen so far (inclusive) is zero. Digit 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above && (disp_val[4*i +: 4] == 4'h0);
      blank_mask[i] = (BLANK_LEADING != 0) && (i != 0) && zero_above;
    end
  end

  // Mux the active digit by comparison rather than a variable part-select so
  // non-power-of-two digit counts never index past the buffer.
  always_comb begin
    digit_sel  = '0;
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos == POS_W'(i)) begin
        digit_sel[i] = 1'b1;
        sel_nibble   = disp_val[4*i +: 4];
        sel_dp       = disp_dp[i];
        sel_blank    = blank_mask[i];
      end
    end
  end

  seven_seg_hex_decode u_decode (
    .nibble (sel_nibble),
    .dp     (sel_dp),
    .blank  (sel_blank),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      pos        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      an         <= '1;
      seg        <= SEG_IDLE;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
      if (tc) begin
        pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
      end

      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end

      // The display buffer only changes between frames, so a frame never
      // mixes digits from two values. A load on the wrap cycle bypasses the
      // shadow so it is not delayed by a whole extra frame.
      if (wrap) begin
        disp_val <= load ? value : shadow_val;
        disp_dp  <= load ? dp_in : shadow_dp;
      end

      // Both outputs come from one-hot/registered state, so at most one
      // anode is ever low and no overlap cycle can occur.
      an  <= enable ? ~digit_sel : '1;
      seg <= enable ? (cur_seg ^ SEG_XOR) : SEG_IDLE;
    end
  end

endmodule
